// File: rtl/data_mem_load_unit_if.sv
// Load unit bundle: execute-side request and result plus the memory read
// channel. The unit takes the slave side.
interface data_mem_load_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              Req_Valid;
  logic              Req_Ready;
  logic [2:0]        Req_Op;
  logic [ADDR_W-1:0] Req_Addr;
  logic [4:0]        Req_Rd;
  logic              Flush;
  logic              Mem_Req_Valid;
  logic              Mem_Req_Ready;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Rsp_Valid;
  logic [DATA_W-1:0] Mem_Rsp_Data;
  logic              Rsp_Valid;
  logic [DATA_W-1:0] Rsp_Data;
  logic [4:0]        Rsp_Rd;
  logic [1:0]        Rsp_Err;

  modport master (
    output Req_Valid, Req_Op, Req_Addr, Req_Rd, Flush,
    output Mem_Req_Ready, Mem_Rsp_Valid, Mem_Rsp_Data,
    input  Req_Ready, Mem_Req_Valid, Mem_Addr,
    input  Rsp_Valid, Rsp_Data, Rsp_Rd, Rsp_Err
  );

  modport slave (
    input  Req_Valid, Req_Op, Req_Addr, Req_Rd, Flush,
    input  Mem_Req_Ready, Mem_Rsp_Valid, Mem_Rsp_Data,
    output Req_Ready, Mem_Req_Valid, Mem_Addr,
    output Rsp_Valid, Rsp_Data, Rsp_Rd, Rsp_Err
  );
endinterface

// File: rtl/data_mem_load_unit.sv
// Data memory load unit: aligned word reads, split/merge of boundary-crossing
// loads, sign/zero extension and a one-cycle tagged result.
module data_mem_load_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic                 Clk,
  input logic                 Rst_N,
  data_mem_load_unit_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        rd_q, rd_d;
  logic              split_q, split_d;
  logic [DATA_W-1:0] w0_q, w0_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic [1:0]        err_q, err_d;

  function automatic logic [3:0] op_size(input logic [2:0] op);
    logic [3:0] s;
    unique case (op)
      3'd0, 3'd3: s = 4'd1;
      3'd1, 3'd4: s = 4'd2;
      3'd6:       s = 4'd8;
      default:    s = 4'd4;
    endcase
    return s;
  endfunction

  logic [OFF_W-1:0] in_off;
  logic             in_legal;
  logic             in_split;

  assign in_off   = bus.Req_Addr[OFF_W-1:0];
  assign in_legal = (bus.Req_Op <= 3'd4) ||
                    (DATA_W == 64 && bus.Req_Op != 3'd7);
  assign in_split = ({{(4-OFF_W){1'b0}}, in_off} +
                     op_size(bus.Req_Op)) > 4'(BYTES);

  // The low word comes straight off the bus for a single access,
  // otherwise from W0; the high word is always the live response.
  logic [DATA_W-1:0] lo_w;
  logic [DATA_W-1:0] m;
  logic [DATA_W-1:0] ext;
  logic [ADDR_W-1:0] base;

  assign lo_w = (state_q == WAIT0) ? bus.Mem_Rsp_Data : w0_q;
  assign m    = DATA_W'({bus.Mem_Rsp_Data, lo_w} >>
                        {addr_q[OFF_W-1:0], 3'b000});
  assign base = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    ext = '0;
    unique case (op_q)
      3'd0:    ext = DATA_W'($signed(m[7:0]));
      3'd1:    ext = DATA_W'($signed(m[15:0]));
      3'd2:    ext = DATA_W'($signed(m[31:0]));
      3'd3:    ext = DATA_W'(m[7:0]);
      3'd4:    ext = DATA_W'(m[15:0]);
      3'd5:    ext = DATA_W'(m[31:0]);
      default: ext = m;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    split_d  = split_q;
    w0_d     = w0_q;
    data_d   = data_q;
    rsp_rd_d = rsp_rd_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Req_Valid && !bus.Flush) begin
          op_d    = bus.Req_Op;
          addr_d  = bus.Req_Addr;
          rd_d    = bus.Req_Rd;
          split_d = in_split;
          if (!in_legal) begin
            state_d  = RESP;
            err_d    = 2'b10;
            data_d   = '0;
            rsp_rd_d = bus.Req_Rd;
          end else if (in_split && !MISALIGN_EN) begin
            state_d  = RESP;
            err_d    = 2'b01;
            data_d   = '0;
            rsp_rd_d = bus.Req_Rd;
          end else begin
            state_d = REQ0;
          end
        end
      end
      REQ0, REQ1: begin
        // A flush racing the handshake still leaves a read in flight.
        if (bus.Mem_Req_Ready) begin
          if (bus.Flush)
            state_d = DRAIN;
          else
            state_d = (state_q == REQ0) ? WAIT0 : WAIT1;
        end else if (bus.Flush) begin
          state_d = IDLE;
        end
      end
      WAIT0, WAIT1: begin
        if (bus.Flush) begin
          state_d = bus.Mem_Rsp_Valid ? IDLE : DRAIN;
        end else if (bus.Mem_Rsp_Valid) begin
          if (state_q == WAIT0)
            w0_d = bus.Mem_Rsp_Data;
          if (state_q == WAIT0 && split_q) begin
            state_d = REQ1;
          end else begin
            state_d  = RESP;
            data_d   = ext;
            err_d    = 2'b00;
            rsp_rd_d = rd_q;
          end
        end
      end
      RESP:    state_d = IDLE;
      DRAIN:   if (bus.Mem_Rsp_Valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      rd_q     <= '0;
      split_q  <= 1'b0;
      w0_q     <= '0;
      data_q   <= '0;
      rsp_rd_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      split_q  <= split_d;
      w0_q     <= w0_d;
      data_q   <= data_d;
      rsp_rd_q <= rsp_rd_d;
      err_q    <= err_d;
    end
  end

  assign bus.Req_Ready     = (state_q == IDLE);
  assign bus.Mem_Req_Valid = (state_q == REQ0) || (state_q == REQ1);
  assign bus.Mem_Addr      = (state_q == REQ0) ? base :
                             (state_q == REQ1) ? base + ADDR_W'(BYTES) :
                             '0;
  assign bus.Rsp_Valid     = (state_q == RESP) && !bus.Flush;
  assign bus.Rsp_Data      = data_q;
  assign bus.Rsp_Rd        = rsp_rd_q;
  assign bus.Rsp_Err       = err_q;
endmodule

// File: tb/tb_data_mem_load_unit.sv
// Bench for data_mem_load_unit: three instances (32-bit split, 32-bit
// no-split, 64-bit) against a byte-level reference model of memory.
module tb_data_mem_load_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  logic        rv, fl;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [4:0]  rd;
  int          sel;
  int          lat, stall;
  int          wcnt;
  logic        mrdy;
  logic [2:0]  mrv;
  logic [63:0] rdat [3];
  int          cnt [3];
  int          hs_total = 0;
  logic [31:0] hs_addr [8];
  logic [7:0]  mem [4096];

  data_mem_load_unit_if #(.DATA_W(32), .ADDR_W(32)) b0 ();
  data_mem_load_unit_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
  data_mem_load_unit_if #(.DATA_W(64), .ADDR_W(32)) b2 ();

  data_mem_load_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut0 (
    .Clk(clk), .Rst_N(rst_n), .bus(b0.slave));
  data_mem_load_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) dut1 (
    .Clk(clk), .Rst_N(rst_n), .bus(b1.slave));
  data_mem_load_unit #(.DATA_W(64), .ADDR_W(32), .MISALIGN_EN(1'b1)) dut2 (
    .Clk(clk), .Rst_N(rst_n), .bus(b2.slave));

  assign b0.Req_Valid = rv && sel == 0;
  assign b1.Req_Valid = rv && sel == 1;
  assign b2.Req_Valid = rv && sel == 2;
  assign b0.Req_Op = op;   assign b1.Req_Op = op;   assign b2.Req_Op = op;
  assign b0.Req_Addr = addr; assign b1.Req_Addr = addr; assign b2.Req_Addr = addr;
  assign b0.Req_Rd = rd;   assign b1.Req_Rd = rd;   assign b2.Req_Rd = rd;
  assign b0.Flush = fl;    assign b1.Flush = fl;    assign b2.Flush = fl;
  assign mrdy = !(stall > 0 && wcnt < stall);
  assign b0.Mem_Req_Ready = mrdy;
  assign b1.Mem_Req_Ready = mrdy;
  assign b2.Mem_Req_Ready = mrdy;
  assign b0.Mem_Rsp_Valid = mrv[0];
  assign b1.Mem_Rsp_Valid = mrv[1];
  assign b2.Mem_Rsp_Valid = mrv[2];
  assign b0.Mem_Rsp_Data = rdat[0][31:0];
  assign b1.Mem_Rsp_Data = rdat[1][31:0];
  assign b2.Mem_Rsp_Data = rdat[2];

  logic [2:0]  rrdy, mqv, rsv;
  logic [31:0] mad [3];
  logic [63:0] rsd [3];
  logic [4:0]  rsr [3];
  logic [1:0]  rse [3];
  assign rrdy = {b2.Req_Ready, b1.Req_Ready, b0.Req_Ready};
  assign mqv  = {b2.Mem_Req_Valid, b1.Mem_Req_Valid, b0.Mem_Req_Valid};
  assign rsv  = {b2.Rsp_Valid, b1.Rsp_Valid, b0.Rsp_Valid};
  assign mad[0] = b0.Mem_Addr; assign mad[1] = b1.Mem_Addr; assign mad[2] = b2.Mem_Addr;
  assign rsd[0] = {32'h0, b0.Rsp_Data};
  assign rsd[1] = {32'h0, b1.Rsp_Data};
  assign rsd[2] = b2.Rsp_Data;
  assign rsr[0] = b0.Rsp_Rd; assign rsr[1] = b1.Rsp_Rd; assign rsr[2] = b2.Rsp_Rd;
  assign rse[0] = b0.Rsp_Err; assign rse[1] = b1.Rsp_Err; assign rse[2] = b2.Rsp_Err;

  function automatic logic [63:0] rdword(input int nb, input logic [31:0] a);
    logic [63:0] w = '0;
    for (int i = 0; i < nb; i++) w[8*i +: 8] = mem[(a + 32'(i)) & 32'hFFF];
    return w;
  endfunction

  // Memory: stalls each request for 'stall' cycles, answers 'lat' cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrv  <= '0;
      wcnt <= 0;
      for (int k = 0; k < 3; k++) cnt[k] <= 0;
    end else begin
      wcnt <= (mqv[sel] && !mrdy) ? wcnt + 1 : 0;
      for (int k = 0; k < 3; k++) begin
        mrv[k] <= 1'b0;
        if (cnt[k] == 1) begin
          mrv[k] <= 1'b1;
          cnt[k] <= 0;
        end else if (cnt[k] > 1) begin
          cnt[k] <= cnt[k] - 1;
        end
        if (mqv[k] && mrdy) begin
          rdat[k] <= rdword(k == 2 ? 8 : 4, mad[k]);
          hs_addr[hs_total % 8] <= mad[k];
          hs_total <= hs_total + 1;
          if (lat <= 1) mrv[k] <= 1'b1;
          else cnt[k] <= lat - 1;
        end
      end
    end
  end

  function automatic int sz(input logic [2:0] o);
    case (o)
      3'd0, 3'd3: return 1;
      3'd1, 3'd4: return 2;
      3'd6:       return 8;
      default:    return 4;
    endcase
  endfunction

  // Reference: pick size bytes little-endian from memory, then extend.
  task automatic model(input int s, input logic [2:0] o, input logic [31:0] a,
                       output logic [63:0] d, output logic [1:0] e, output int na);
    int  dw    = (s == 2) ? 64 : 32;
    int  nb    = dw / 8;
    int  n     = sz(o);
    bit  legal = (o <= 3'd4) || (dw == 64 && o != 3'd7);
    bit  split = (int'(a % 32'(nb)) + n) > nb;
    d = '0; e = 2'b00; na = 0;
    if (!legal) e = 2'b10;
    else if (split && s == 1) e = 2'b01;
    else begin
      na = split ? 2 : 1;
      for (int i = 0; i < n; i++) d[8*i +: 8] = mem[(a + 32'(i)) & 32'hFFF];
      if (o <= 3'd2 && n < 8 && d[8*n-1])
        for (int i = 8*n; i < 64; i++) d[i] = 1'b1;
      if (dw == 32) d[63:32] = '0;
    end
  endtask

  task automatic do_load(input int s, input logic [2:0] o, input logic [31:0] a,
                         output logic [63:0] got);
    logic [63:0] ed;
    logic [1:0]  ee;
    logic [4:0]  tag;
    logic [31:0] base, ea;
    int na, h0, n, el, nb;
    bit seen;
    model(s, o, a, ed, ee, na);
    nb   = (s == 2) ? 8 : 4;
    base = a & ~32'(nb - 1);
    tag  = 5'($urandom);
    el   = (ee != 2'b00) ? 1 : 1 + na * (1 + lat + stall);
    @(negedge clk);
    sel = s; op = o; addr = a; rd = tag; rv = 1'b1;
    h0 = hs_total;
    @(negedge clk);
    rv = 1'b0; n = 1; seen = 0; got = '0;
    while (!seen && n <= 60) begin
      if (mqv[s]) begin
        ea = base + 32'(nb) * 32'(hs_total - h0);
        vec++;
        if (mad[s] !== ea) begin
          errs++;
          $display("FAIL mem_addr: op %0d addr %h got %h exp %h", o, a, mad[s], ea);
        end
      end
      if (rsv[s]) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    vec++;
    if (!seen) begin
      errs++;
      $display("FAIL rsp_timeout: op %0d addr %h no Rsp_Valid in 60 cycles", o, a);
    end else begin
      got = rsd[s];
      vec++;
      if (n !== el) begin
        errs++;
        $display("FAIL latency: op %0d addr %h got %0d exp %0d", o, a, n, el);
      end
      vec++;
      if (rsd[s] !== ed) begin
        errs++;
        $display("FAIL rsp_data: dut %0d op %0d addr %h got %h exp %h", s, o, a, rsd[s], ed);
      end
      vec++;
      if (rse[s] !== ee) begin
        errs++;
        $display("FAIL rsp_err: op %0d addr %h got %b exp %b", o, a, rse[s], ee);
      end
      vec++;
      if (rsr[s] !== tag) begin
        errs++;
        $display("FAIL rsp_rd: got %0d exp %0d", rsr[s], tag);
      end
      @(negedge clk);
      vec++;
      if (rsv[s] !== 1'b0 || rrdy[s] !== 1'b1) begin
        errs++;
        $display("FAIL rsp_pulse: valid %b ready %b exp 0 1", rsv[s], rrdy[s]);
      end
    end
    vec++;
    if (hs_total - h0 !== na) begin
      errs++;
      $display("FAIL accesses: op %0d addr %h got %0d exp %0d", o, a, hs_total - h0, na);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (rrdy[k] !== 1'b1 || mqv[k] !== 1'b0 || rsv[k] !== 1'b0 ||
          mad[k] !== 32'h0 || rsd[k] !== 64'h0 || rse[k] !== 2'b00 || rsr[k] !== 5'd0) begin
        errs++;
        $display("FAIL reset: dut %0d rdy %b mreq %b rsp %b addr %h data %h err %b rd %0d",
                 k, rrdy[k], mqv[k], rsv[k], mad[k], rsd[k], rse[k], rsr[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic lit(input string nm, input logic [63:0] g, input logic [63:0] e);
    vec++;
    if (g !== e) begin
      errs++;
      $display("FAIL %s: got %h exp %h", nm, g, e);
    end
  endtask

  task automatic test_single;
    logic [63:0] g;
    lat = 1; stall = 0;
    do_load(0, 3'd0, 32'h103, g); lit("lb_103", g, 64'hFFFFFF88);
    do_load(0, 3'd3, 32'h103, g); lit("lbu_103", g, 64'h88);
    do_load(0, 3'd4, 32'h101, g); lit("lhu_101", g, 64'h7766);
  endtask

  task automatic test_split;
    logic [63:0] g;
    lat = 1; stall = 0;
    do_load(0, 3'd1, 32'h103, g); lit("lh_103", g, 64'hFFFFAA88);
    do_load(0, 3'd2, 32'h102, g); lit("lw_102", g, 64'hBBAA8877);
    stall = 3;
    do_load(0, 3'd2, 32'h100, g); lit("lw_stall", g, 64'h88776655);
    stall = 0;
  endtask

  task automatic test_misalign_err;
    logic [63:0] g;
    lat = 1; stall = 0;
    do_load(1, 3'd2, 32'h102, g); lit("noma_lw_102", g, 64'h0);
    do_load(1, 3'd2, 32'h100, g); lit("noma_lw_100", g, 64'h88776655);
  endtask

  task automatic test_illegal;
    logic [63:0] g;
    do_load(0, 3'd6, 32'h100, g);
    vec++;
    if (rse[0] !== 2'b10) begin
      errs++;
      $display("FAIL ld_on_32: got %b exp 10", rse[0]);
    end
    do_load(0, 3'd5, 32'h100, g);
    do_load(2, 3'd7, 32'h0, g);
  endtask

  task automatic test_dw64;
    logic [63:0] g;
    do_load(2, 3'd2, 32'h4, g); lit("lw64_4", g, 64'hFFFFFFFF80000000);
    do_load(2, 3'd5, 32'h4, g); lit("lwu64_4", g, 64'h0000000080000000);
    do_load(2, 3'd6, 32'h0, g); lit("ld64_0", g, 64'h8000000011223344);
  endtask

  task automatic test_wrap;
    logic [63:0] g;
    do_load(0, 3'd1, 32'hFFFFFFFF, g);
    lit("wrap_addr", {32'h0, hs_addr[(hs_total - 1) % 8]}, 64'h0);
  endtask

  task automatic test_flush_wait0;
    logic [63:0] held;
    bit seen = 0;
    lat = 3; stall = 0;
    held = rsd[0];
    @(negedge clk); sel = 0; op = 3'd2; addr = 32'h100; rv = 1'b1;
    @(negedge clk); rv = 1'b0; seen |= rsv[0];
    @(negedge clk); fl = 1'b1; seen |= rsv[0];
    @(negedge clk); fl = 1'b0; seen |= rsv[0];
    lit("drain_busy", {63'h0, rrdy[0]}, 64'h0);
    @(negedge clk); seen |= rsv[0];
    lit("drain_rsp", {62'h0, rrdy[0], mrv[0]}, 64'h1);
    @(negedge clk); seen |= rsv[0];
    lit("drain_done", {63'h0, rrdy[0]}, 64'h1);
    repeat (3) begin @(negedge clk); seen |= rsv[0]; end
    lit("drain_no_rsp", {63'h0, seen}, 64'h0);
    lit("drain_hold", rsd[0], held);
    lat = 1;
  endtask

  task automatic test_flush_resp;
    lat = 1; stall = 0;
    @(negedge clk); sel = 0; op = 3'd2; addr = 32'h100; rv = 1'b1;
    @(negedge clk); rv = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 fl = 1'b1;
    @(negedge clk);
    lit("flush_resp_valid", {63'h0, rsv[0]}, 64'h0);
    fl = 1'b0;
    @(negedge clk);
    lit("flush_resp_idle", {62'h0, rrdy[0], rsv[0]}, 64'h2);
  endtask

  task automatic test_flush_req;
    int h0;
    lat = 2; stall = 0;
    @(negedge clk); sel = 0; op = 3'd0; addr = 32'h100; rv = 1'b1;
    @(negedge clk); rv = 1'b0; fl = 1'b1;
    @(negedge clk); fl = 1'b0;
    lit("flush_req_hs_drain", {63'h0, rrdy[0]}, 64'h0);
    @(negedge clk);
    lit("flush_req_hs_wait", {63'h0, rrdy[0]}, 64'h0);
    @(negedge clk);
    lit("flush_req_hs_idle", {62'h0, rrdy[0], rsv[0]}, 64'h2);
    stall = 3;
    h0 = hs_total;
    @(negedge clk); op = 3'd0; addr = 32'h104; rv = 1'b1;
    @(negedge clk); rv = 1'b0; fl = 1'b1;
    @(negedge clk); fl = 1'b0;
    lit("flush_req_stall", {62'h0, rrdy[0], mqv[0]}, 64'h2);
    lit("flush_req_no_hs", 64'(hs_total - h0), 64'h0);
    stall = 0; lat = 1;
    @(negedge clk);
  endtask

  task automatic test_flush_idle;
    @(negedge clk); sel = 0; op = 3'd2; addr = 32'h100; rv = 1'b1; fl = 1'b1;
    @(negedge clk); rv = 1'b0; fl = 1'b0;
    lit("flush_idle", {62'h0, rrdy[0], mqv[0]}, 64'h2);
  endtask

  task automatic test_reset_midop;
    logic [63:0] g;
    lat = 3; stall = 0;
    @(negedge clk); sel = 0; op = 3'd2; addr = 32'h100; rv = 1'b1;
    @(negedge clk); rv = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 lit("async_reset", {62'h0, rrdy[0], mqv[0]}, 64'h2);
    @(negedge clk); rst_n = 1'b1;
    lat = 1;
    do_load(0, 3'd4, 32'h106, g); lit("after_reset", g, 64'hDDCC);
  endtask

  task automatic test_random;
    logic [63:0] g;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 60; i++) begin
        lat   = $urandom_range(1, 3);
        stall = $urandom_range(0, 2);
        do_load(s, 3'($urandom_range(0, 7)), $urandom(), g);
      end
    end
    lat = 1; stall = 0;
  endtask

  task automatic test_back_to_back;
    logic [63:0] g;
    lat = 1; stall = 0;
    for (int i = 0; i < 8; i++)
      do_load(0, 3'($urandom_range(0, 4)), 32'h100 + 32'(i), g);
  endtask

  initial begin
    rst_n = 1'b0;
    rv = 1'b0; fl = 1'b0; sel = 0; op = '0; addr = '0; rd = '0;
    lat = 1; stall = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    {mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]} = 32'h88776655;
    {mem[16'h107], mem[16'h106], mem[16'h105], mem[16'h104]} = 32'hDDCCBBAA;
    {mem[7], mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]} = 64'h8000000011223344;
    test_reset;
    test_single;
    test_split;
    test_misalign_err;
    test_illegal;
    test_dw64;
    test_wrap;
    test_flush_wait0;
    test_flush_resp;
    test_flush_req;
    test_flush_idle;
    test_reset_midop;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
